// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: queue entry layout, default
// geometry, reset PC and the pointer-width helper.
package fetch_pkg;

  localparam int FETCH_DATA_W      = 16;
  localparam int FETCH_INSTR_BYTES = 2;
  localparam int FETCH_QDEPTH      = 4;
  localparam logic [FETCH_DATA_W-1:0] FETCH_RESET_PC = 16'h0000;

  // Width of the stale-response counter. Several back-to-back redirects can
  // stack up more discards than the queue depth, so it is sized generously.
  localparam int DROP_W = 8;

  typedef struct packed {
    logic [FETCH_DATA_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] data;
    logic                    filled;
  } fetch_entry_t;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// In-order fetch queue storage. Entries are allocated at request time with
// the fetch PC, filled in order as responses return, and popped from the
// head. Three pointers (alloc, fill, read) carry one extra wrap bit so the
// occupancy and the number of still-unfilled entries fall out as differences.
module fetch_queue_ram
  import fetch_pkg::*;
#(
  parameter  int QDEPTH = FETCH_QDEPTH,
  localparam int PTR_W  = clog2(QDEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    alloc_en,
  input  logic [FETCH_DATA_W-1:0] alloc_pc,
  input  logic                    fill_en,
  input  logic [FETCH_DATA_W-1:0] fill_data,
  input  logic                    pop_en,
  output logic                    full,
  output logic [PTR_W:0]          unfilled,
  output fetch_entry_t            head
);

  fetch_entry_t   mem_q [QDEPTH];
  fetch_entry_t   mem_d [QDEPTH];
  logic [PTR_W:0] wr_q, wr_d;
  logic [PTR_W:0] fill_q, fill_d;
  logic [PTR_W:0] rd_q, rd_d;
  logic [PTR_W:0] count;

  // Next-state for storage and pointers; a clear wins over alloc/fill/pop.
  always_comb begin
    count    = wr_q - rd_q;
    full     = (count == (PTR_W+1)'(QDEPTH));
    unfilled = wr_q - fill_q;
    head     = mem_q[rd_q[PTR_W-1:0]];
    mem_d    = mem_q;
    wr_d     = wr_q;
    fill_d   = fill_q;
    rd_d     = rd_q;
    if (clear) begin
      wr_d   = '0;
      fill_d = '0;
      rd_d   = '0;
      for (int i = 0; i < QDEPTH; i++) mem_d[i].filled = 1'b0;
    end else begin
      if (alloc_en && !full) begin
        mem_d[wr_q[PTR_W-1:0]] = '{pc: alloc_pc, data: '0, filled: 1'b0};
        wr_d = wr_q + 1'b1;
      end
      if (fill_en && (unfilled != '0)) begin
        mem_d[fill_q[PTR_W-1:0]].data   = fill_data;
        mem_d[fill_q[PTR_W-1:0]].filled = 1'b1;
        fill_d = fill_q + 1'b1;
      end
      if (pop_en && head.filled) begin
        mem_d[rd_q[PTR_W-1:0]].filled = 1'b0;
        rd_d = rd_q + 1'b1;
      end
    end
  end

  // Register storage and pointers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q   <= '0;
      fill_q <= '0;
      rd_q   <= '0;
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q   <= wr_d;
      fill_q <= fill_d;
      rd_q   <= rd_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: PC register, sequential next-PC, redirect, decoupled
// instruction-memory handshake and an in-order queue feeding decode.
// Optional feature macro FETCH_PERF_CNT_EN adds saturating stall and flush
// counters as extra outputs. DATA_W must match the package entry width.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int                DATA_W      = FETCH_DATA_W,
  parameter int                INSTR_BYTES = FETCH_INSTR_BYTES,
  parameter int                QDEPTH      = FETCH_QDEPTH,
  parameter logic [DATA_W-1:0] RESET_PC    = FETCH_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [DATA_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [DATA_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [DATA_W-1:0] inst_pc,
  output logic [DATA_W-1:0] inst_pc_next
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int PTR_W = clog2(QDEPTH);

  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              hold_q, hold_d;
  logic              q_full;
  logic [PTR_W:0]    q_unfilled;
  fetch_entry_t      q_head;
  logic              req_fire;
  logic              fill_en;
  logic              pop_en;

  // Handshakes, next PC and stale-response bookkeeping. hold_q keeps the
  // request line quiet for the first cycle out of reset.
  always_comb begin
    imem_req_valid = !hold_q && !q_full && !redirect_valid;
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    fill_en        = imem_resp_valid && !redirect_valid && (drop_q == '0);
    inst_valid     = q_head.filled;
    pop_en         = inst_valid && inst_ready && !redirect_valid;
    inst_data      = inst_valid ? q_head.data : '0;
    inst_pc        = inst_valid ? q_head.pc : '0;
    inst_pc_next   = inst_valid ? (q_head.pc + DATA_W'(INSTR_BYTES)) : '0;
    hold_d         = 1'b0;
    pc_d           = pc_q;
    drop_d         = drop_q;
    if (redirect_valid) begin
      pc_d   = redirect_pc;
      drop_d = drop_q + DROP_W'(q_unfilled) - DROP_W'(imem_resp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + DATA_W'(INSTR_BYTES);
      if (imem_resp_valid && (drop_q != '0)) drop_d = drop_q - DROP_W'(1);
    end
  end

  // PC, drop counter and post-reset hold flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
      hold_q <= 1'b1;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
      hold_q <= hold_d;
    end
  end

  // A response must always have a destination: a pending discard or an unfilled entry.
  always_ff @(posedge clk) begin
    if (rst) assert (!imem_resp_valid || (drop_q != '0) || (q_unfilled != '0));
  end

  fetch_queue_ram #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .alloc_en  (req_fire),
    .alloc_pc  (pc_q),
    .fill_en   (fill_en),
    .fill_data (imem_resp_data),
    .pop_en    (pop_en),
    .full      (q_full),
    .unfilled  (q_unfilled),
    .head      (q_head)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;

  // Saturating event counters: cycles without an accepted request, redirect cycles.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!req_fire && (stall_q != '1)) stall_d = stall_q + 32'd1;
    if (redirect_valid && (flush_q != '1)) flush_d = flush_q + 32'd1;
  end

  // Counters clear on reset, so reset cycles are never counted as stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_flush_cnt    = flush_q;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with a latency-configurable in-order
// memory model and a scoreboard of expected {pc, data} per accepted request.
module tb_fetch_queue_unit;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } memReq_t;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] data;
  } expEntry_t;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [15:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [15:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst_data;
  logic [15:0] inst_pc;
  logic [15:0] inst_pc_next;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_cnt;
`endif

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          memLat = 1;
  logic [15:0] modelPc = 16'h0000;
  memReq_t     pending[$];
  expEntry_t   expQ[$];
  logic [15:0] acceptLog[$];
  logic [15:0] popPcLog[$];
  logic [15:0] popNextLog[$];
  logic [15:0] popDataLog[$];
  int          popCycleLog[$];
  int          base;

  fetch_queue_unit dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_pc_next    (inst_pc_next)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_cnt    (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] memData(input logic [15:0] a);
    return (a * 16'd3) ^ 16'h5A3C;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstV, input logic reqReadyV, input logic instReadyV,
                               input logic redirV, input logic [15:0] redirPcV);
    @(negedge clk);
    rst            = rstV;
    imem_req_ready = reqReadyV;
    inst_ready     = instReadyV;
    redirect_valid = redirV;
    redirect_pc    = redirPcV;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearLogs();
    acceptLog.delete();
    popPcLog.delete();
    popNextLog.delete();
    popDataLog.delete();
    popCycleLog.delete();
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    clearLogs();
  endtask

  task automatic waitPops(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while ((popPcLog.size() < target) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    #4;
    checkOutput(tag, 32'(popPcLog.size() >= target), 32'd1);
  endtask

  task automatic waitAccepts(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while ((acceptLog.size() < target) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    #4;
    checkOutput(tag, 32'(acceptLog.size() >= target), 32'd1);
  endtask

  // Memory model drives responses at +1 after negedge; monitor samples at +3.
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = 16'h0000;
    forever begin
      @(negedge clk);
      cyc++;
      #1;
      if ((pending.size() > 0) && (pending[0].due <= cyc)) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = memData(pending[0].addr);
        void'(pending.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 16'h0000;
      end
      #2;
      if (!rst) begin
        pending.delete();
        expQ.delete();
        modelPc = 16'h0000;
      end else begin
        if (redirect_valid) begin
          expQ.delete();
          modelPc = redirect_pc;
        end else if (inst_valid && inst_ready) begin
          checkOutput("scoreboard_nonempty", 32'(expQ.size() != 0), 32'd1);
          if (expQ.size() != 0) begin
            expEntry_t   e;
            logic [15:0] nextPc;
            e      = expQ.pop_front();
            nextPc = e.pc + 16'd2;
            checkOutput("inst_pc", inst_pc, e.pc);
            checkOutput("inst_data", inst_data, e.data);
            checkOutput("inst_pc_next", inst_pc_next, nextPc);
          end
          popPcLog.push_back(inst_pc);
          popNextLog.push_back(inst_pc_next);
          popDataLog.push_back(inst_data);
          popCycleLog.push_back(cyc);
        end
        if (imem_req_valid && imem_req_ready) begin
          checkOutput("req_addr", imem_req_addr, modelPc);
          pending.push_back('{addr: imem_req_addr, due: cyc + memLat});
          expQ.push_back('{pc: modelPc, data: memData(modelPc)});
          acceptLog.push_back(imem_req_addr);
          modelPc = modelPc + 16'd2;
        end
      end
    end
  end

  // Hard stop if the directed sequence ever stalls.
  initial begin
    #400000;
    $display("[TB] FAIL global_timeout observed=timeout expected=finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;

    // Reset state
    doReset();
    #2;
    checkOutput("rst_req_valid", imem_req_valid, 0);
    checkOutput("rst_req_addr", imem_req_addr, 16'h0000);
    checkOutput("rst_inst_valid", inst_valid, 0);
    checkOutput("rst_inst_data", inst_data, 0);
    checkOutput("rst_inst_pc", inst_pc, 0);
    checkOutput("rst_inst_pc_next", inst_pc_next, 0);

    // 1: latency 1, free flow
    $display("[TB] test 1 streaming");
    memLat = 1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    waitPops(4, 20, "t1_wait_pops");
    checkOutput("t1_pc0", popPcLog[0], 16'h0000);
    checkOutput("t1_pc1", popPcLog[1], 16'h0002);
    checkOutput("t1_pc2", popPcLog[2], 16'h0004);
    checkOutput("t1_pc3", popPcLog[3], 16'h0006);
    checkOutput("t1_one_per_cycle", 32'(popCycleLog[3] - popCycleLog[0]), 32'd3);

    // 2: decode back-pressure fills the queue
    $display("[TB] test 2 back-pressure");
    doReset();
    memLat = 1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    idle(9);
    #2;
    checkOutput("t2_accepts", 32'(acceptLog.size()), 32'd4);
    checkOutput("t2_full_req_valid", imem_req_valid, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    #2;
    checkOutput("t2_pop_no_same_cycle_req", imem_req_valid, 0);
    waitPops(4, 20, "t2_wait_pops");
    checkOutput("t2_pc0", popPcLog[0], 16'h0000);
    checkOutput("t2_pc3", popPcLog[3], 16'h0006);
    waitAccepts(5, 10, "t2_wait_resume");
    checkOutput("t2_resume_addr", acceptLog[4], 16'h0008);

    // 3: redirect with two outstanding requests, latency 3
    $display("[TB] test 3 redirect with outstanding");
    doReset();
    memLat = 3;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 16'h0100);
    #2;
    checkOutput("t3_no_req_on_redirect", imem_req_valid, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    #2;
    checkOutput("t3_req_after_redirect", imem_req_valid, 1);
    checkOutput("t3_req_addr_target", imem_req_addr, 16'h0100);
    waitPops(3, 40, "t3_wait_pops");
    checkOutput("t3_first_pc", popPcLog[0], 16'h0100);
    checkOutput("t3_first_data", popDataLog[0], memData(16'h0100));
    checkOutput("t3_third_pc", popPcLog[2], 16'h0104);

    // 4: PC wrap at the top of the address space
    $display("[TB] test 4 wrap");
    doReset();
    memLat = 1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFC);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    waitPops(3, 20, "t4_wait_pops");
    checkOutput("t4_pc_fffe", popPcLog[1], 16'hFFFE);
    checkOutput("t4_next_wrap", popNextLog[1], 16'h0000);
    checkOutput("t4_pc_wrap", popPcLog[2], 16'h0000);
    checkOutput("t4_req_addr_wrap", acceptLog[2], 16'h0000);

    // 5: redirect, response and pop in one cycle, latency 2
    $display("[TB] test 5 redirect+resp+pop");
    doReset();
    memLat = 2;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    idle(7);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h0200);
    #2;
    checkOutput("t5_head_valid_at_redirect", inst_valid, 1);
    base = popPcLog.size();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    waitPops(base + 3, 30, "t5_wait_pops");
    checkOutput("t5_pc0", popPcLog[base], 16'h0200);
    checkOutput("t5_pc1", popPcLog[base + 1], 16'h0202);
    checkOutput("t5_pc2", popPcLog[base + 2], 16'h0204);

    // 6: mid-stream reset with the queue full
    $display("[TB] test 6 mid-stream reset");
    doReset();
    memLat = 1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    idle(7);
    #2;
    checkOutput("t6_full_req_valid", imem_req_valid, 0);
    checkOutput("t6_head_valid", inst_valid, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    clearLogs();
    #2;
    checkOutput("t6_inst_valid", inst_valid, 0);
    checkOutput("t6_req_addr", imem_req_addr, 16'h0000);
    checkOutput("t6_req_valid", imem_req_valid, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    waitPops(1, 20, "t6_wait_pops");
    checkOutput("t6_first_pc", popPcLog[0], 16'h0000);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
